fetch_cache_unit: RTL and testbench
===================================

Name: fetch_cache_unit

Overview:
Parametrised instruction-fetch stage: PC register, redirect mux and a direct-mapped instruction cache with a refill state machine toward a line-wide instruction memory port. It replaces the fixed 4-word, always-hit fetch path. Line size and set count are configurable, and it adds miss handling, downstream stall, redirect squash, flush and a miss counter. Its outputs feed the decode stage register.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, >=1.
SETS, 16, number of direct-mapped lines; power of two, >=2.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clock  input  1  single clock; all state on rising edge.
resetN  input  1  asynchronous active-low reset.
branchTarget  input  32  redirect target.
pcSource  input  1  1 = redirect PC to branchTarget this cycle.
stall  input  1  decode cannot accept; hold fetch outputs.
flush  input  1  invalidate all cache lines.
memReq  output  1  line refill request, held until memReady.
memAddr  output  32  line-aligned refill address.
memReady  input  1  memLine valid this cycle; one-cycle pulse.
memLine  input  32*LINE_WORDS  refill data; word 0 in LSBs.
instruction  output  32  fetched instruction (registered).
nextPc  output  32  address of instruction + 4 (registered).
valid  output  1  instruction/nextPc valid.
hit  output  1  current PC hits in cache (combinational, RUN only).
missCount  output  32  number of refills started; wraps.

Behaviour:
- Address split: offset = log2(LINE_WORDS)+2 bits; index = log2(SETS) bits; tag = remaining upper bits. PC[1:0] ignored.
- Storage per set: valid bit, tag, line. Lookup is combinational on PC. hit = validBit[index] && tag match && state==RUN.
- Reset (async, resetN=0): PC=RESET_PC, all valid bits 0, state RUN, valid=0, instruction=0, nextPc=0, memReq=0, memAddr=0, missCount=0, pending redirect cleared.
- States: RUN, MISS, FILL.
- RUN, pcSource=1: PC<=branchTarget; valid<=0. Redirect overrides stall and hit.
- RUN, stall=1 (no redirect): PC, instruction, nextPc, valid held.
- RUN, hit, no stall: instruction<=selected word; nextPc<=PC+4; valid<=1; PC<=PC+4. Sustains one instruction per cycle.
- RUN, miss, no stall: valid<=0; memAddr<=PC with offset bits cleared; memReq<=1; missCount<=missCount+1; go to MISS.
- MISS: memReq held at 1, memAddr stable. On memReady: write line, set valid bit and tag, memReq<=0, go to FILL. A line-wide write takes one cycle.
- FILL: go to RUN. The next RUN cycle re-looks-up the same PC and hits, so miss latency = refill wait + 2 cycles.
- Redirect during MISS/FILL: latch branchTarget as the pending target (a later redirect overwrites it). The refill always completes; memory is never aborted. On entering RUN, PC<=pending target and the pending flag clears. valid stays 0 throughout MISS/FILL.
- stall in MISS/FILL: no effect on the refill; valid stays 0.
- flush: clears all valid bits next edge, in any state. Flush on the memReady edge: the flush wins and the filled line ends up invalid. A line filled after the flush edge is kept.
- PC wraps modulo 2^32. nextPc is computed mod 2^32.
- missCount wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-refill: memReq drops immediately (async); the memory side must tolerate an abandoned request.

Decomposition:
- Shared package fetch_pkg: state encoding (RUN/MISS/FILL), derived widths OFFSET_BITS/INDEX_BITS/TAG_BITS as functions of the parameters, NOP constant.
- One sub-module icache_array: valid/tag/data storage with combinational read (index → valid, tag, line), synchronous line write, and a flush-all port.
- fetch_cache_unit holds the PC, FSM, output registers and counter.

Test Plan:
- Reset, then release with LINE_WORDS=4, SETS=16 → memReq=1, memAddr=0x0, missCount=1. memReady with memLine words {0x11,0x22,0x33,0x44} → two cycles later valid=1, instruction=0x11, nextPc=0x4, then 0x22, 0x33, 0x44 on consecutive cycles.
- Hit stream, then stall=1 for 3 cycles → instruction/nextPc/valid frozen. Release → sequence continues with no gap or duplicate.
- pcSource=1, branchTarget=0x100 while hitting → next cycle valid=0. Miss on 0x100, memAddr=0x100; after refill, instruction = word 0 of the new line, nextPc=0x104.
- Redirect to 0x40 while in MISS for 0x20 → the 0x20 line still fills (memReq until memReady), then fetch resumes at 0x40 with no instruction from 0x20 issued.
- Conflict: fetch 0x000 then redirect to 0x100 (same index, SETS=16, 16B lines) → second miss evicts the first; returning to 0x000 misses again; missCount=3.
- flush asserted on the memReady cycle → line not valid and refetched; missCount increments again. PC 0xFFFF_FFFC hit → nextPc=0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: refill FSM encoding, NOP word and cache address-split widths.
// Widths are functions so each module derives them from its own LINE_WORDS/SETS parameters.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    FILL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int line_words, input int sets);
    return 32 - offset_bits(line_words) - index_bits(sets);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line store: combinational read, one-cycle full-line write, flush-all of valid bits.
// A flush on the same edge as a write wins, so the written line is left invalid.
module icache_array
  import fetch_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  localparam int INDEX_BITS = index_bits(SETS),
  localparam int TAG_BITS   = tag_bits(LINE_WORDS, SETS),
  localparam int LINE_BITS  = 32 * LINE_WORDS
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  flush,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [LINE_BITS-1:0]  wr_line
);

  logic [SETS-1:0]      valid_bits;
  logic [TAG_BITS-1:0]  tags  [SETS];
  logic [LINE_BITS-1:0] lines [SETS];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      valid_bits <= '0;
    end else if (flush) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only ever read under a set valid bit.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

endmodule

// File: rtl/fetch_cache_unit.sv
// Fetch stage: PC, redirect, direct-mapped I-cache with refill FSM; one instruction/cycle on hit.
// Miss costs refill wait + 2 cycles; stall holds outputs in RUN; redirects during refill are deferred.
module fetch_cache_unit
  import fetch_pkg::*;
#(
  parameter int          LINE_WORDS = 4,
  parameter int          SETS       = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic [31:0]             branchTarget,
  input  logic                    pcSource,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    memReq,
  output logic [31:0]             memAddr,
  input  logic                    memReady,
  input  logic [32*LINE_WORDS-1:0] memLine,
  output logic [31:0]             instruction,
  output logic [31:0]             nextPc,
  output logic                    valid,
  output logic                    hit,
  output logic [31:0]             missCount
);

  localparam int OFFSET_BITS = offset_bits(LINE_WORDS);
  localparam int INDEX_BITS  = index_bits(SETS);
  localparam int TAG_BITS    = tag_bits(LINE_WORDS, SETS);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic         pend_vld;

  logic                      line_vld;
  logic [TAG_BITS-1:0]       line_tag;
  logic [32*LINE_WORDS-1:0]  line_dat;
  logic [31:0]               word;
  logic                      fill_en;

  assign fill_en = (state == MISS) && memReady;

  icache_array #(
    .LINE_WORDS(LINE_WORDS),
    .SETS      (SETS)
  ) u_array (
    .clock   (clock),
    .resetN  (resetN),
    .flush   (flush),
    .rd_index(pc[OFFSET_BITS +: INDEX_BITS]),
    .rd_valid(line_vld),
    .rd_tag  (line_tag),
    .rd_line (line_dat),
    .wr_en   (fill_en),
    .wr_index(memAddr[OFFSET_BITS +: INDEX_BITS]),
    .wr_tag  (memAddr[31 -: TAG_BITS]),
    .wr_line (memLine)
  );

  generate
    if (LINE_WORDS == 1) begin : g_one
      assign word = line_dat;
    end else begin : g_sel
      logic [31:0] words [LINE_WORDS];
      for (genvar w = 0; w < LINE_WORDS; w++) begin : g_w
        assign words[w] = line_dat[32*w +: 32];
      end
      assign word = words[pc[OFFSET_BITS-1:2]];
    end
  endgenerate

  assign hit = line_vld && (line_tag == pc[31 -: TAG_BITS]) && (state == RUN);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pend_pc     <= '0;
      pend_vld    <= 1'b0;
      valid       <= 1'b0;
      instruction <= '0;
      nextPc      <= '0;
      memReq      <= 1'b0;
      memAddr     <= '0;
      missCount   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (pcSource) begin
            pc    <= branchTarget;
            valid <= 1'b0;
          end else if (!stall) begin
            if (hit) begin
              instruction <= word;
              nextPc      <= pc + 32'd4;
              valid       <= 1'b1;
              pc          <= pc + 32'd4;
            end else begin
              valid     <= 1'b0;
              memAddr   <= {pc[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
              memReq    <= 1'b1;
              missCount <= missCount + 32'd1;
              state     <= MISS;
            end
          end
        end
        MISS: begin
          // The refill is never aborted; a redirect waits until the line is in.
          if (pcSource) begin
            pend_vld <= 1'b1;
            pend_pc  <= branchTarget;
          end
          if (memReady) begin
            memReq <= 1'b0;
            state  <= FILL;
          end
        end
        FILL: begin
          state    <= RUN;
          pend_vld <= 1'b0;
          if (pcSource) begin
            pc <= branchTarget;
          end else if (pend_vld) begin
            pc <= pend_pc;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_cache_unit.sv
// Directed then random stimulus for fetch_cache_unit, checked against a set/tag/word cache model.
module tb_fetch_cache_unit;
  localparam int          LW   = 4;
  localparam int          SETS = 16;
  localparam logic [31:0] LB   = 32'(LW * 4);
  localparam logic [31:0] SPAN = 32'(LW * 4 * SETS);

  logic              clock = 1'b0;
  logic              resetN;
  logic [31:0]       branchTarget;
  logic              pcSource, stall, flush, memReady;
  logic [32*LW-1:0]  memLine;
  logic              memReq, valid, hit;
  logic [31:0]       memAddr, instruction, nextPc, missCount;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  fetch_cache_unit #(.LINE_WORDS(LW), .SETS(SETS), .RESET_PC(32'h0)) dut (
    .clock(clock), .resetN(resetN), .branchTarget(branchTarget), .pcSource(pcSource),
    .stall(stall), .flush(flush), .memReq(memReq), .memAddr(memAddr), .memReady(memReady),
    .memLine(memLine), .instruction(instruction), .nextPc(nextPc), .valid(valid),
    .hit(hit), .missCount(missCount)
  );

  // Reference model: 0 = fetching, 1 = waiting on memory, 2 = line just written
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_next, m_addr, m_cnt, m_pend_pc;
  logic        m_vo, m_req, m_pend;
  bit          c_vld  [SETS];
  logic [31:0] c_tag  [SETS];
  logic [31:0] c_word [SETS][LW];

  bit               fixed;
  logic [32*LW-1:0] fixed_line;

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LB) % 32'(SETS));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / SPAN;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a % LB) / 32'd4);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_5A03;
  endfunction

  function automatic logic [32*LW-1:0] line_of(input logic [31:0] base);
    logic [32*LW-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = mem_word(base + 32'(4 * i));
    return l;
  endfunction

  function automatic bit m_hit();
    int s;
    s = set_of(m_pc);
    return (m_phase == 0) && c_vld[s] && (c_tag[s] == tag_of(m_pc));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_instr = '0; m_next = '0; m_addr = '0; m_cnt = '0;
    m_pend_pc = '0; m_vo = 1'b0; m_req = 1'b0; m_pend = 1'b0;
    for (int i = 0; i < SETS; i++) c_vld[i] = 1'b0;
  endtask

  task automatic model_edge();
    int s;
    bit h;
    h = m_hit();
    s = set_of(m_pc);
    case (m_phase)
      0: begin
        if (pcSource) begin
          m_pc = branchTarget; m_vo = 1'b0;
        end else if (!stall) begin
          if (h) begin
            m_instr = c_word[s][word_of(m_pc)]; m_next = m_pc + 32'd4; m_vo = 1'b1; m_pc = m_pc + 32'd4;
          end else begin
            m_vo = 1'b0; m_addr = m_pc - (m_pc % LB); m_req = 1'b1; m_cnt = m_cnt + 32'd1; m_phase = 1;
          end
        end
      end
      1: begin
        if (pcSource) begin
          m_pend = 1'b1; m_pend_pc = branchTarget;
        end
        if (memReady) begin
          s = set_of(m_addr);
          c_vld[s] = 1'b1;
          c_tag[s] = tag_of(m_addr);
          for (int i = 0; i < LW; i++) c_word[s][i] = memLine[32*i +: 32];
          m_req = 1'b0; m_phase = 2;
        end
      end
      default: begin
        m_phase = 0;
        if (pcSource) m_pc = branchTarget;
        else if (m_pend) m_pc = m_pend_pc;
        m_pend = 1'b0;
      end
    endcase
    if (flush) for (int i = 0; i < SETS; i++) c_vld[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("memReq", {31'b0, memReq}, {31'b0, m_req});
    chk("memAddr", memAddr, m_addr);
    chk("valid", {31'b0, valid}, {31'b0, m_vo});
    chk("instruction", instruction, m_instr);
    chk("nextPc", nextPc, m_next);
    chk("missCount", missCount, m_cnt);
    chk("hit", {31'b0, hit}, {31'b0, m_hit()});
  endtask

  task automatic step(input logic pcs, input logic [31:0] bt, input logic st,
                      input logic fl, input logic rdy);
    pcSource = pcs; branchTarget = bt; stall = st; flush = fl; memReady = rdy;
    memLine = fixed ? fixed_line : line_of(m_addr);
    fixed = 1'b0;
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic refill();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  logic        r_pcs, r_st, r_fl, r_rdy;
  logic [31:0] r_bt;

  initial begin
    resetN = 1'b0; pcSource = 1'b0; branchTarget = '0; stall = 1'b0; flush = 1'b0;
    memReady = 1'b0; memLine = '0; fixed = 1'b0; fixed_line = '0;
    model_reset();
    @(negedge clock);
    check_all();
    resetN = 1'b1;

    // Cold miss at the reset PC, then a hand-built line
    idle(1);
    chk("cold_req", {31'b0, memReq}, 32'd1);
    chk("cold_count", missCount, 32'd1);
    idle(2);
    fixed = 1'b1;
    fixed_line = {32'h44, 32'h33, 32'h22, 32'h11};
    refill();
    chk("first_instr", instruction, 32'h11);
    chk("first_next", nextPc, 32'h4);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("stall_hold", instruction, 32'h11);
    idle(1);
    chk("after_stall", instruction, 32'h22);
    idle(2);
    chk("line_end", instruction, 32'h44);

    // Redirect while hitting, then a conflicting line at the same index
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("redirect_squash", {31'b0, valid}, 32'd0);
    idle(1);
    chk("redirect_addr", memAddr, 32'h100);
    refill();
    chk("redirect_instr", instruction, mem_word(32'h100));
    chk("redirect_next", nextPc, 32'h104);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("evicted_count", missCount, 32'd3);
    refill();

    // Redirect during a refill is deferred until the line lands
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    idle(1);
    refill();
    chk("deferred_addr", memAddr, 32'h40);
    chk("deferred_valid", {31'b0, valid}, 32'd0);

    // Flush on the memReady edge leaves the line invalid
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("flush_refetch", missCount, 32'd6);
    refill();
    chk("after_flush", instruction, mem_word(32'h40));

    // PC wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    idle(1);
    refill();
    chk("wrap_next", nextPc, 32'h0);

    for (int i = 0; i < 600; i++) begin
      r_pcs = ($urandom_range(7) == 0);
      r_bt  = ($urandom_range(3) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'($urandom_range(255)) * 32'd4;
      r_st  = ($urandom_range(3) == 0);
      r_fl  = ($urandom_range(31) == 0);
      r_rdy = m_req && ($urandom_range(2) == 0);
      step(r_pcs, r_bt, r_st, r_fl, r_rdy);
    end

    // Reset dropped in the middle of a refill
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4 && !m_req; k++) idle(1);
    chk("pre_reset_req", {31'b0, memReq}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    chk("async_req_drop", {31'b0, memReq}, 32'd0);
    chk("async_count", missCount, 32'd0);
    model_reset();
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
